// File: rtl/debounce_evt_pkg.sv
// ============================================================================
// Module   : debounce_evt_pkg
// Purpose  : Shared channel FSM state type and polarity names for debounce_evt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_evt_pkg;

    typedef enum logic [1:0] {
        ST_INACTIVE   = 2'd0,
        ST_PEND_ACT   = 2'd1,
        ST_ACTIVE     = 2'd2,
        ST_PEND_INACT = 2'd3
    } chan_state_t;

    localparam string c_POL_HIGH = "HIGH";
    localparam string c_POL_LOW  = "LOW";

endpackage

`default_nettype wire

// File: rtl/debounce_evt_chan.sv
// ============================================================================
// Module   : debounce_evt_chan
// Purpose  : One debounce channel: hold-time FSM, counter, level and edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_evt_chan
    import debounce_evt_pkg::*;
#(
    parameter string POLARITY      = c_POL_HIGH,
    parameter int    TIMEOUT       = 50000,
    parameter int    TIMEOUT_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sample,
    output logic o_data_out,
    output logic o_assert_pulse,
    output logic o_deassert_pulse
);

    localparam logic                     c_INV     = (POLARITY == c_POL_LOW);
    localparam logic [TIMEOUT_WIDTH-1:0] c_LAST    = TIMEOUT_WIDTH'(TIMEOUT - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] c_ONE     = TIMEOUT_WIDTH'(1);
    localparam bit                       c_INSTANT = (TIMEOUT == 1);

    chan_state_t              r_state;
    chan_state_t              w_state_nxt;
    logic [TIMEOUT_WIDTH-1:0] r_cnt;
    logic [TIMEOUT_WIDTH-1:0] w_cnt_nxt;
    logic                     r_data_out;
    logic                     r_assert;
    logic                     r_deassert;
    logic                     w_act;
    logic                     w_level;
    logic                     w_level_nxt;

    // Work internally in "active = 1" terms regardless of pin polarity.
    assign w_act   = i_sample ^ c_INV;
    assign w_level = r_data_out ^ c_INV;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INACTIVE: begin
                if (w_act) begin
                    if (c_INSTANT) begin
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_state_nxt = ST_PEND_ACT;
                        w_cnt_nxt   = c_ONE;
                    end
                end
            end
            ST_PEND_ACT: begin
                if (!w_act) begin
                    w_state_nxt = ST_INACTIVE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            ST_ACTIVE: begin
                if (!w_act) begin
                    if (c_INSTANT) begin
                        w_state_nxt = ST_INACTIVE;
                    end else begin
                        w_state_nxt = ST_PEND_INACT;
                        w_cnt_nxt   = c_ONE;
                    end
                end
            end
            ST_PEND_INACT: begin
                if (w_act) begin
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt = ST_INACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_INACTIVE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_level_nxt = (w_state_nxt == ST_ACTIVE) || (w_state_nxt == ST_PEND_INACT);
    end

    // Pulses compare the next level with the current one so they line up
    // exactly with the data_out transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_INACTIVE;
            r_cnt      <= '0;
            r_data_out <= c_INV;
            r_assert   <= 1'b0;
            r_deassert <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_data_out <= w_level_nxt ^ c_INV;
            r_assert   <= w_level_nxt & ~w_level;
            r_deassert <= ~w_level_nxt & w_level;
        end
    end

    assign o_data_out       = r_data_out;
    assign o_assert_pulse   = r_assert;
    assign o_deassert_pulse = r_deassert;

endmodule

`default_nettype wire

// File: rtl/debounce_evt.sv
// ============================================================================
// Module   : debounce_evt
// Purpose  : WIDTH-channel input debouncer with sticky assert events and irq.
//            Define DEBOUNCE_EVT_SYNC_EN to add a two-flop input synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_evt
    import debounce_evt_pkg::*;
#(
    parameter int    WIDTH         = 32,
    parameter string POLARITY      = c_POL_HIGH,
    parameter int    TIMEOUT       = 50000,
    parameter int    TIMEOUT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] assert_pulse,
    output logic [WIDTH-1:0] deassert_pulse,
    input  logic [WIDTH-1:0] evt_clear,
    input  logic [WIDTH-1:0] evt_mask,
    output logic [WIDTH-1:0] evt_status,
    output logic             irq
);

    logic [WIDTH-1:0] w_sample;
    logic [WIDTH-1:0] r_evt_status;
    logic             r_irq;

`ifdef DEBOUNCE_EVT_SYNC_EN
    localparam logic [WIDTH-1:0] c_IDLE = {WIDTH{(POLARITY == c_POL_LOW)}};

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    // Synchroniser resets to the inactive level so reset release looks idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= c_IDLE;
            r_sync2 <= c_IDLE;
        end else begin
            r_sync1 <= data_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = data_in;
`endif

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            debounce_evt_chan #(
                .POLARITY      (POLARITY),
                .TIMEOUT       (TIMEOUT),
                .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
            ) u_chan (
                .clk              (clk),
                .rst              (reset),
                .i_sample         (w_sample[gi]),
                .o_data_out       (data_out[gi]),
                .o_assert_pulse   (assert_pulse[gi]),
                .o_deassert_pulse (deassert_pulse[gi])
            );
        end
    endgenerate

    // Set has priority over clear so a simultaneous event is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_evt_status <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_evt_status <= (r_evt_status & ~evt_clear) | assert_pulse;
            r_irq        <= |(r_evt_status & evt_mask);
        end
    end

    assign evt_status = r_evt_status;
    assign irq        = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_debounce_evt.sv
// ============================================================================
// Module   : tb_debounce_evt
// Purpose  : Self-checking bench for debounce_evt (WIDTH=4, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_evt;

`ifdef DEBOUNCE_EVT_SYNC_EN
    localparam int c_LAT = 2;
`else
    localparam int c_LAT = 0;
`endif
    localparam int c_T = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din, clr, mask, dout, ap, dp, st;
    logic       irq;
    logic [3:0] din_l, clr_l, mask_l, dout_l, ap_l, dp_l, st_l;
    logic       irq_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    debounce_evt #(.WIDTH(4), .POLARITY("HIGH"), .TIMEOUT(8), .TIMEOUT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .data_in(din), .data_out(dout),
        .assert_pulse(ap), .deassert_pulse(dp), .evt_clear(clr),
        .evt_mask(mask), .evt_status(st), .irq(irq)
    );

    debounce_evt #(.WIDTH(4), .POLARITY("LOW"), .TIMEOUT(8), .TIMEOUT_WIDTH(4)) dut_low (
        .clk(clk), .reset(reset), .data_in(din_l), .data_out(dout_l),
        .assert_pulse(ap_l), .deassert_pulse(dp_l), .evt_clear(clr_l),
        .evt_mask(mask_l), .evt_status(st_l), .irq(irq_l)
    );

    // Reference model: a level flips once the sample has disagreed with it
    // for c_T consecutive edges; events/irq follow with plain register lag.
    logic [3:0] m_lvl, m_ap, m_dp, m_st, m_pipe0, m_pipe1;
    logic       m_irq;
    int         m_run [4];

    task automatic model_edge();
        logic [3:0] s;
        if (reset) begin
            m_lvl = '0; m_ap = '0; m_dp = '0; m_st = '0; m_irq = 1'b0;
            m_pipe0 = '0; m_pipe1 = '0;
            for (int c = 0; c < 4; c++) m_run[c] = 0;
        end else begin
            if (c_LAT == 2) begin
                s = m_pipe1; m_pipe1 = m_pipe0; m_pipe0 = din;
            end else begin
                s = din;
            end
            m_irq = |(m_st & mask);
            m_st  = (m_st & ~clr) | m_ap;
            m_ap  = '0;
            m_dp  = '0;
            for (int c = 0; c < 4; c++) begin
                m_run[c] = (s[c] != m_lvl[c]) ? m_run[c] + 1 : 0;
                if (m_run[c] == c_T) begin
                    m_lvl[c] = s[c];
                    m_run[c] = 0;
                    if (s[c]) m_ap[c] = 1'b1; else m_dp[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", {15'd0, dout, ap, dp, st, irq}, {15'd0, m_lvl, m_ap, m_dp, m_st, m_irq});
    endtask

    task automatic do_reset();
        reset = 1'b1; din = '0; clr = '0; din_l = 4'hF;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] din;
        logic [3:0] clr;
        logic [3:0] mask;
        int         rpt;
        logic [3:0] out;
        logic [3:0] ap;
        logic [3:0] dp;
        logic [3:0] st;
        logic       irq;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int edges, hits, hit_edge;
        bit found;

        tbl[0] = '{4'b0001, 4'b0000, 4'b0001, 7 + c_LAT, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[1] = '{4'b0001, 4'b0000, 4'b0001, 1,         4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0};
        tbl[2] = '{4'b0001, 4'b0000, 4'b0001, 1,         4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[3] = '{4'b0001, 4'b0000, 4'b0001, 1,         4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1};
        tbl[4] = '{4'b0000, 4'b0000, 4'b0001, 7,         4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1};
        tbl[5] = '{4'b0000, 4'b0000, 4'b0001, 1,         4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b1};
        tbl[6] = '{4'b0000, 4'b0000, 4'b0001, 1,         4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1};
        tbl[7] = '{4'b0000, 4'b0001, 4'b0001, 1,         4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        tbl[8] = '{4'b0000, 4'b0000, 4'b0001, 1,         4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        reset = 1'b1; din = '0; clr = '0; mask = '0; din_l = 4'hF; clr_l = '0; mask_l = '0;
        do_reset();
        check("reset_outs", {15'd0, dout, ap, dp, st, irq}, 32'd0);
        check("reset_low_dout", {28'd0, dout_l}, 32'hF);

        // Assert, deassert, sticky status and clear on channel 0.
        mask = 4'b0001;
        for (int i = 0; i < 9; i++) begin
            for (int r = 0; r < tbl[i].rpt; r++) begin
                din = tbl[i].din; clr = tbl[i].clr; mask = tbl[i].mask;
                step();
                check($sformatf("tbl_row%0d", i), {15'd0, dout, ap, dp, st, irq},
                      {15'd0, tbl[i].out, tbl[i].ap, tbl[i].dp, tbl[i].st, tbl[i].irq});
            end
        end
        clr = '0;

        // Glitch on channel 1 restarts the count.
        do_reset();
        hits = 0; hit_edge = 0; edges = 0;
        for (int e = 0; e < 16 + c_LAT; e++) begin
            din[1] = (e == 7) ? 1'b0 : 1'b1;
            step();
            edges++;
            if (ap[1]) begin hits++; hit_edge = edges; end
        end
        check("glitch_pulses", hits, 1);
        check("glitch_edge", hit_edge, 16 + c_LAT);

        // Clear colliding with assert pulse on channel 2.
        do_reset();
        mask = 4'b0100; din[2] = 1'b1; found = 0;
        for (int e = 0; e < 20 && !found; e++) begin
            step();
            if (ap[2]) found = 1;
        end
        check("clr_wait_pulse", {31'd0, found}, 32'd1);
        clr[2] = 1'b1;
        step();
        check("clr_same_cycle_status", {31'd0, st[2]}, 32'd1);
        step();
        check("clr_alone_status", {31'd0, st[2]}, 32'd0);
        check("clr_irq_lag", {31'd0, irq}, 32'd1);
        clr[2] = 1'b0;
        step();
        check("clr_irq_drop", {31'd0, irq}, 32'd0);

        // Reset in the middle of a pending count on channel 3.
        do_reset();
        din[3] = 1'b1;
        repeat (5 + c_LAT) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midpend_reset_outs", {15'd0, dout, ap, dp, st, irq}, 32'd0);
        step();
        edges = 1;
        check("midpend_release_pulse", {28'd0, ap | dp}, 32'd0);
        found = 0;
        for (int e = 0; e < 20 && !found; e++) begin
            if (ap[3]) found = 1;
            else begin step(); edges++; end
        end
        check("midpend_full_count", edges, 8 + c_LAT);

        // Active-low instance.
        do_reset();
        check("low_reset_dout", {28'd0, dout_l}, 32'hF);
        din_l[0] = 1'b0; edges = 0; found = 0;
        for (int e = 0; e < 20 && !found; e++) begin
            step();
            edges++;
            if (dout_l[0] == 1'b0) found = 1;
        end
        check("low_accept_edge", edges, 8 + c_LAT);
        check("low_assert_pulse", {28'd0, ap_l}, 32'd1);

        // Randomised traffic against the model.
        do_reset();
        mask = 4'($urandom);
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(5) == 0) din[c] = ~din[c];
            clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
            if ($urandom_range(31) == 0) mask = 4'($urandom);
            reset = ($urandom_range(299) == 0);
            step();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
